// File: rtl/counter_gen.sv
// counter_gen: prescaled up/down counter with wrap or saturate at the bounds
// 0 and MAX_VAL, synchronous load, a one-cycle terminal-count pulse and a
// sticky overflow flag.
//
// Ports:
//   clk       in   single clock, all state changes on the rising edge
//   rst       in   synchronous reset, active-low
//   cnt_en    in   count enable; advances the prescaler
//   dir       in   1 = count up, 0 = count down (used only on a tick)
//   sat_mode  in   1 = saturate at the bound, 0 = wrap (used only on a tick)
//   load      in   synchronous load strobe, wins over a coincident tick
//   load_val  in   load value, clamped to MAX_VAL
//   clr_ovf   in   clears the sticky ovf flag (a coincident set wins)
//   cnt       out  registered counter value, always within 0..MAX_VAL
//   tc        out  one-cycle pulse after every tick that hits a bound
//   ovf       out  sticky flag, set on every tick that hits a bound
module counter_gen #(
    parameter int WIDTH    = 6,
    parameter int RST_VAL  = 1,
    parameter int MAX_VAL  = 63,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic             dir,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_V    = WIDTH'(RST_VAL);
    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("counter_gen: WIDTH out of range 1..32");
    end
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("counter_gen: PRESCALE out of range 1..65535");
    end
    if (MAX_VAL < 1) begin : g_bad_max
        $error("counter_gen: MAX_VAL must be at least 1");
    end
    if (RST_VAL < 0 || RST_VAL > MAX_VAL) begin : g_bad_rst
        $error("counter_gen: RST_VAL out of range 0..MAX_VAL");
    end

    // Load values above the upper bound are clamped so cnt stays in range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_V) ? MAX_V : v;
    endfunction

    // One count step; at a bound either hold (saturate) or jump to the
    // opposite bound (wrap). The bound compare happens before the add, so
    // no WIDTH-bit carry or borrow ever reaches cnt.
    function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] c,
                                                    input logic             up,
                                                    input logic             sat);
        if (up) begin
            if (c == MAX_V) return sat ? MAX_V : '0;
            return c + WIDTH'(1);
        end
        if (c == '0) return sat ? '0 : MAX_V;
        return c - WIDTH'(1);
    endfunction

    logic [PRE_W-1:0] pre;
    logic             tick;
    logic             at_bound;

    // With PRESCALE=1, PRE_LAST is 0 and pre never leaves 0, so tick = cnt_en.
    assign tick = cnt_en && (pre == PRE_LAST);

    always_comb begin
        at_bound = 1'b0;
        if (dir) at_bound = (cnt == MAX_V);
        else     at_bound = (cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= RST_V;
            pre <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                // A tick landing on a load edge is dropped, prescale restarts.
                cnt <= clamp_load(load_val);
                pre <= '0;
            end else if (tick) begin
                cnt <= step_count(cnt, dir, sat_mode);
                pre <= '0;
                tc  <= at_bound;
            end else if (cnt_en) begin
                pre <= pre + PRE_W'(1);
            end
            // Set has priority over clear on the same edge.
            ovf <= (ovf & ~clr_ovf) | (tick & ~load & at_bound);
        end
    end

endmodule

// File: tb/tb_counter_gen.sv
module tb_counter_gen;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst, cnt_en, dir, sat_mode, load, clr_ovf;
    logic [W-1:0] load_val;
    logic [W-1:0] cnt_a, cnt_b;
    logic         tc_a, tc_b, ovf_a, ovf_b;

    always #5 clk = ~clk;

    // Default configuration.
    counter_gen #(.WIDTH(W), .RST_VAL(1), .MAX_VAL(63), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .cnt_en(cnt_en), .dir(dir), .sat_mode(sat_mode),
        .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
        .cnt(cnt_a), .tc(tc_a), .ovf(ovf_a));

    // Prescaled, narrow-range configuration.
    counter_gen #(.WIDTH(W), .RST_VAL(1), .MAX_VAL(9), .PRESCALE(4)) dut_b (
        .clk(clk), .rst(rst), .cnt_en(cnt_en), .dir(dir), .sat_mode(sat_mode),
        .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
        .cnt(cnt_b), .tc(tc_b), .ovf(ovf_b));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int maxv;
        int rstv;
        int presc;
        int cnt;
        int pre;   // enabled cycles seen since the last step
        bit tc;
        bit ovf;
    } model_t;

    model_t ma, mb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: the counter lives on the ring 0..maxv, stepping is
    // modular arithmetic, and a step is due once presc enabled cycles elapse.
    function automatic model_t model_step(input model_t m);
        model_t n;
        bit     due;
        bit     hit;
        n = m;
        if (!rst) begin
            n.cnt = m.rstv; n.pre = 0; n.tc = 0; n.ovf = 0;
            return n;
        end
        due  = cnt_en && (m.pre + 1 == m.presc);
        hit  = dir ? (m.cnt == m.maxv) : (m.cnt == 0);
        n.tc = 0;
        if (clr_ovf) n.ovf = 0;
        if (load) begin
            n.cnt = (int'(load_val) > m.maxv) ? m.maxv : int'(load_val);
            n.pre = 0;
        end else if (due) begin
            n.pre = 0;
            if (hit) begin n.tc = 1; n.ovf = 1; end
            if (hit && sat_mode) n.cnt = m.cnt;
            else if (dir)        n.cnt = (m.cnt + 1) % (m.maxv + 1);
            else                 n.cnt = (m.cnt + m.maxv) % (m.maxv + 1);
        end else if (cnt_en) begin
            n.pre = m.pre + 1;
        end
        return n;
    endfunction

    task automatic drive(input bit r, input bit e, input bit d, input bit s,
                         input bit l, input logic [W-1:0] lv, input bit c);
        rst = r; cnt_en = e; dir = d; sat_mode = s; load = l; load_val = lv; clr_ovf = c;
    endtask

    // One clock edge: advance both models, then compare all outputs.
    task automatic cycle();
        @(posedge clk);
        ma = model_step(ma);
        mb = model_step(mb);
        #1;
        chk("a_cnt", 32'(cnt_a), 32'(ma.cnt));
        chk("a_tc",  32'(tc_a),  32'(ma.tc));
        chk("a_ovf", 32'(ovf_a), 32'(ma.ovf));
        chk("b_cnt", 32'(cnt_b), 32'(mb.cnt));
        chk("b_tc",  32'(tc_b),  32'(mb.tc));
        chk("b_ovf", 32'(ovf_b), 32'(mb.ovf));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        ma = '{maxv: 63, rstv: 1, presc: 1, cnt: 0, pre: 0, tc: 0, ovf: 0};
        mb = '{maxv: 9,  rstv: 1, presc: 4, cnt: 0, pre: 0, tc: 0, ovf: 0};
        drive(0, 1, 1, 0, 1, 6'd33, 1);
        @(negedge clk);

        // Reset, then a full up-count wrap on the default counter.
        cycles(2);
        chk("rst_cnt_a", 32'(cnt_a), 32'd1);
        chk("rst_tc_a",  32'(tc_a),  32'd0);
        chk("rst_ovf_b", 32'(ovf_b), 32'd0);
        drive(1, 1, 1, 0, 0, 6'd0, 0);
        cycles(62);
        chk("up_top_a", 32'(cnt_a), 32'd63);
        cycle();
        chk("wrap_cnt_a", 32'(cnt_a), 32'd0);
        chk("wrap_tc_a",  32'(tc_a),  32'd1);
        chk("wrap_ovf_a", 32'(ovf_a), 32'd1);

        // Prescale by 4 and the stall from dropping cnt_en for 3 cycles.
        drive(1, 0, 1, 0, 1, 6'd0, 0);
        cycle();
        chk("tc_one_cycle_a", 32'(tc_a), 32'd0);
        drive(1, 1, 1, 0, 0, 6'd0, 0);
        cycles(3);
        chk("pre_hold_b", 32'(cnt_b), 32'd0);
        cycle();
        chk("pre_step_b", 32'(cnt_b), 32'd1);
        cycles(2);
        drive(1, 0, 1, 0, 0, 6'd0, 0);
        cycles(3);
        drive(1, 1, 1, 0, 0, 6'd0, 0);
        cycle();
        chk("stall_hold_b", 32'(cnt_b), 32'd1);
        cycle();
        chk("stall_step_b", 32'(cnt_b), 32'd2);

        // Load clamp overriding a coincident tick; prescaler restarts.
        cycles(3);
        drive(1, 1, 1, 0, 1, 6'd15, 0);
        cycle();
        chk("load_clamp_b", 32'(cnt_b), 32'd9);
        chk("load_tc_b",    32'(tc_b),  32'd0);
        chk("load_a",       32'(cnt_a), 32'd15);
        drive(1, 1, 1, 0, 0, 6'd0, 0);
        cycles(3);
        chk("load_pre_clr_b", 32'(cnt_b), 32'd9);
        cycle();
        chk("wrap_cnt_b", 32'(cnt_b), 32'd0);
        chk("wrap_tc_b",  32'(tc_b),  32'd1);
        drive(1, 0, 1, 0, 1, 6'd5, 0);
        cycle();
        chk("load5_b", 32'(cnt_b), 32'd5);

        // Saturating down count from 1: tc on 2nd and 3rd ticks only.
        drive(1, 0, 0, 1, 1, 6'd1, 0);
        cycle();
        drive(1, 0, 0, 1, 0, 6'd0, 1);
        cycle();
        chk("clr_ovf_a", 32'(ovf_a), 32'd0);
        drive(1, 1, 0, 1, 0, 6'd0, 0);
        cycle();
        chk("sat1_cnt_a", 32'(cnt_a), 32'd0);
        chk("sat1_tc_a",  32'(tc_a),  32'd0);
        cycle();
        chk("sat2_cnt_a", 32'(cnt_a), 32'd0);
        chk("sat2_tc_a",  32'(tc_a),  32'd1);
        cycle();
        chk("sat3_tc_a",  32'(tc_a),  32'd1);
        chk("sat3_ovf_a", 32'(ovf_a), 32'd1);
        drive(1, 0, 0, 1, 0, 6'd0, 1);
        cycle();
        chk("sat_clr_a", 32'(ovf_a), 32'd0);

        // Coincident set and clear keeps ovf; clear alone then drops it.
        drive(1, 1, 0, 1, 0, 6'd0, 1);
        cycle();
        chk("set_clr_ovf_a", 32'(ovf_a), 32'd1);
        drive(1, 0, 0, 1, 0, 6'd0, 1);
        cycle();
        chk("clr_only_ovf_a", 32'(ovf_a), 32'd0);

        // Reset mid-prescale with a coincident load.
        drive(1, 0, 1, 0, 1, 6'd7, 0);
        cycle();
        drive(1, 1, 1, 0, 0, 6'd0, 0);
        cycles(2);
        chk("pre2_cnt_b", 32'(cnt_b), 32'd7);
        drive(0, 1, 1, 0, 1, 6'd3, 0);
        cycle();
        chk("rst_mid_cnt_b", 32'(cnt_b), 32'd1);
        chk("rst_mid_tc_b",  32'(tc_b),  32'd0);
        chk("rst_mid_ovf_b", 32'(ovf_b), 32'd0);
        drive(1, 1, 1, 0, 0, 6'd0, 0);
        cycle();
        chk("rel_step_a", 32'(cnt_a), 32'd2);
        cycles(2);
        chk("rel_hold_b", 32'(cnt_b), 32'd1);
        cycle();
        chk("rel_step_b", 32'(cnt_b), 32'd2);

        // Randomized traffic; dir flips rarely so the bounds get reached.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) dir = ~dir;
            rst      = ($urandom_range(0, 149) != 0);
            cnt_en   = ($urandom_range(0, 3) != 0);
            sat_mode = $urandom_range(0, 1) == 1;
            load     = ($urandom_range(0, 23) == 0);
            load_val = W'($urandom);
            clr_ovf  = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
